keycode_to_scancode: RTL and testbench
======================================

KEYCODE_TO_SCANCODE -- requirements
Module: keycode_to_scancode

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: key_data  input  8  keycode to encode; sampled only on acceptance.
REQ-004 SHALL have port: key_broken  input  1  1 = release (break), 0 = press (make); sampled with key_data.
REQ-005 SHALL have port: key_data_stb  input  1  request strobe; accepted only when key_ready=1.
REQ-006 SHALL have port: key_ready  output  1  high only in IDLE.
REQ-007 SHALL have port: tx_data  output  8  current scancode byte to the PS/2 transmitter.
REQ-008 SHALL have port: tx_stb  output  1  tx_data valid; held with tx_data stable until tx_ready.
REQ-009 SHALL have port: tx_ready  input  1  transmitter accepts the byte when tx_stb&&tx_ready.
REQ-010 SHALL have port: key_invalid  output  1  one-cycle pulse for an unmapped keycode.

Function
REQ-011 SHALL accept a request on a cycle with key_data_stb=1 and key_ready=1, latching key_data and key_broken; key_data_stb while busy SHALL be ignored.
REQ-012 SHALL map keycodes to scancode set 2 via keycode_lut. Unprefixed: 01-1A letters (01->1C ... 1A->1A), 1B-24 main-row digits (1B->45, 1C->16 ... 24->46), 25-31, 34-3F, 4C-58 as the set-2 main/keypad codes, 2D->12 (LSHIFT), 2E->14 (LCTRL), 2F->11 (LALT), 30->5A. E0-prefixed: 32->1F, 33->2F, 40->7C, 41->70, 42->6C, 43->7D, 44->7A, 45->71, 46->69, 47->75, 48->72, 49->6B, 4A->74, 59->4A. All others, including 00, unmapped.
REQ-013 SHALL use FSM states IDLE, PREFIX, BREAK, CODE (plus PAUSE_SEQ when configured).
REQ-014 SHALL transition IDLE->PREFIX for E0 keys, IDLE->BREAK for unprefixed break, and IDLE->CODE for unprefixed make, on the cycle after acceptance.
REQ-015 SHALL emit make as [E0] code and break as [E0] F0 code; bytes SHALL be sent strictly in order, one per tx handshake.
REQ-016 SHALL advance PREFIX->BREAK (break) or PREFIX->CODE (make), BREAK->CODE, and CODE->IDLE on each tx handshake; without a handshake, state, tx_data and tx_stb SHALL hold.
REQ-017 SHALL assert tx_stb with the first byte on the cycle after acceptance, and SHALL present the next byte on the cycle after each handshake with no bubble cycle.
REQ-018 SHALL assert key_ready on the cycle after the final byte's handshake, so back-to-back requests are allowed.
REQ-019 SHALL, for an unmapped keycode, pulse key_invalid on the cycle after acceptance, emit no bytes, and remain in IDLE.
REQ-020 SHALL keep tx_stb low in IDLE; tx_ready while tx_stb=0 SHALL have no effect.

Reset
REQ-021 SHALL, when rst is asserted mid-sequence, abort immediately and force IDLE, tx_stb=0, tx_data=00, key_invalid=0, key_ready=1; partial sequences SHALL NOT resume.
REQ-022 SHALL hold outputs at those reset values while rst=1.

Configuration
REQ-023 SHALL, with SCANCODE_PAUSE_EN defined, map keycode 5A (PAUSE); make SHALL emit E1 14 77 E1 F0 14 F0 77 via state PAUSE_SEQ and a 3-bit index, and break SHALL emit no bytes and no key_invalid.
REQ-024 SHALL, without SCANCODE_PAUSE_EN, treat 5A as unmapped, and the PAUSE_SEQ state and index SHALL be absent.

Structure
REQ-025 SHALL place the FSM state enum, prefix constants (E0, F0, E1), and named keycode constants in shared package scancode_pkg.
REQ-026 SHALL place the combinational lookup (keycode -> code byte, e0 flag, valid flag) in sub-module keycode_lut.

Verification
REQ-027 SHALL verify: key_data=01, make, tx_ready=1 -> tx_stb one cycle after accept with 1C, key_ready high next cycle.
REQ-028 SHALL verify: key_data=47, break, tx_ready=1 -> E0, F0, 75 on consecutive cycles.
REQ-029 SHALL verify: key_data=2A, break, tx_ready low 5 cycles -> F0 held stable for 5 cycles, then F0, 29.
REQ-030 SHALL verify: key_data=00 and key_data=7F -> key_invalid one-cycle pulse each, tx_stb never high.
REQ-031 SHALL verify: rst pulsed after the E0 handshake of key 45 break -> tx_stb=0, key_ready=1, next request 01 make -> 1C only.
REQ-032 SHALL verify: with SCANCODE_PAUSE_EN, key 5A make -> 8-byte sequence exact; without it -> key_invalid.

Source files
------------

// File: rtl/scancode_pkg.sv
// Shared types and constants for the keycode to PS/2 set-2 scancode encoder.
// Optional macro SCANCODE_PAUSE_EN adds the PAUSE key sequence.
package scancode_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFIX    = 3'd1,
    BREAK     = 3'd2,
    CODE      = 3'd3
`ifdef SCANCODE_PAUSE_EN
    , PAUSE_SEQ = 3'd4
`endif
  } state_t;

  localparam logic [7:0] PREFIX_E0 = 8'hE0;
  localparam logic [7:0] PREFIX_F0 = 8'hF0;
  localparam logic [7:0] PREFIX_E1 = 8'hE1;

  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_A        = 8'h01;
  localparam logic [7:0] KEY_Z        = 8'h1A;
  localparam logic [7:0] KEY_0        = 8'h1B;
  localparam logic [7:0] KEY_9        = 8'h24;
  localparam logic [7:0] KEY_SPACE    = 8'h2A;
  localparam logic [7:0] KEY_LSHIFT   = 8'h2D;
  localparam logic [7:0] KEY_LCTRL    = 8'h2E;
  localparam logic [7:0] KEY_LALT     = 8'h2F;
  localparam logic [7:0] KEY_ENTER    = 8'h30;
  localparam logic [7:0] KEY_DELETE   = 8'h45;
  localparam logic [7:0] KEY_UP       = 8'h47;
  localparam logic [7:0] KEY_KP_SLASH = 8'h59;
  localparam logic [7:0] KEY_PAUSE    = 8'h5A;

`ifdef SCANCODE_PAUSE_EN
  // PAUSE has no break code; make is a fixed eight-byte burst.
  function automatic logic [7:0] pause_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = PREFIX_E1;
      3'd1:    b = 8'h14;
      3'd2:    b = 8'h77;
      3'd3:    b = PREFIX_E1;
      3'd4:    b = PREFIX_F0;
      3'd5:    b = 8'h14;
      3'd6:    b = PREFIX_F0;
      3'd7:    b = 8'h77;
      default: b = 8'h00;
    endcase
    return b;
  endfunction
`endif

endpackage

// File: rtl/keycode_lut.sv
// Combinational keycode -> set-2 code byte lookup with E0-prefix and valid flags.
module keycode_lut
  import scancode_pkg::*;
(
  input  logic [7:0] keycode_i,
  output logic [7:0] code_o,
  output logic       e0_o,
  output logic       valid_o
);

  always_comb begin
    code_o  = 8'h00;
    e0_o    = 1'b0;
    valid_o = 1'b1;
    case (keycode_i)
      8'h01: code_o = 8'h1C;  8'h02: code_o = 8'h32;  8'h03: code_o = 8'h21;
      8'h04: code_o = 8'h23;  8'h05: code_o = 8'h24;  8'h06: code_o = 8'h2B;
      8'h07: code_o = 8'h34;  8'h08: code_o = 8'h33;  8'h09: code_o = 8'h43;
      8'h0A: code_o = 8'h3B;  8'h0B: code_o = 8'h42;  8'h0C: code_o = 8'h4B;
      8'h0D: code_o = 8'h3A;  8'h0E: code_o = 8'h31;  8'h0F: code_o = 8'h44;
      8'h10: code_o = 8'h4D;  8'h11: code_o = 8'h15;  8'h12: code_o = 8'h2D;
      8'h13: code_o = 8'h1B;  8'h14: code_o = 8'h2C;  8'h15: code_o = 8'h3C;
      8'h16: code_o = 8'h2A;  8'h17: code_o = 8'h1D;  8'h18: code_o = 8'h22;
      8'h19: code_o = 8'h35;  8'h1A: code_o = 8'h1A;
      // Digits: keycode 1B is '0', then '1'..'9'.
      8'h1B: code_o = 8'h45;  8'h1C: code_o = 8'h16;  8'h1D: code_o = 8'h1E;
      8'h1E: code_o = 8'h26;  8'h1F: code_o = 8'h25;  8'h20: code_o = 8'h2E;
      8'h21: code_o = 8'h36;  8'h22: code_o = 8'h3D;  8'h23: code_o = 8'h3E;
      8'h24: code_o = 8'h46;
      8'h25: code_o = 8'h76;  8'h26: code_o = 8'h66;  8'h27: code_o = 8'h0D;
      8'h28: code_o = 8'h58;  8'h29: code_o = 8'h77;  8'h2A: code_o = 8'h29;
      8'h2B: code_o = 8'h05;  8'h2C: code_o = 8'h06;  8'h2D: code_o = 8'h12;
      8'h2E: code_o = 8'h14;  8'h2F: code_o = 8'h11;  8'h30: code_o = 8'h5A;
      8'h31: code_o = 8'h7E;
      8'h34: code_o = 8'h4E;  8'h35: code_o = 8'h55;  8'h36: code_o = 8'h54;
      8'h37: code_o = 8'h5B;  8'h38: code_o = 8'h5D;  8'h39: code_o = 8'h4C;
      8'h3A: code_o = 8'h52;  8'h3B: code_o = 8'h0E;  8'h3C: code_o = 8'h41;
      8'h3D: code_o = 8'h49;  8'h3E: code_o = 8'h4A;  8'h3F: code_o = 8'h59;
      8'h4C: code_o = 8'h70;  8'h4D: code_o = 8'h69;  8'h4E: code_o = 8'h72;
      8'h4F: code_o = 8'h7A;  8'h50: code_o = 8'h6B;  8'h51: code_o = 8'h73;
      8'h52: code_o = 8'h74;  8'h53: code_o = 8'h6C;  8'h54: code_o = 8'h75;
      8'h55: code_o = 8'h7D;  8'h56: code_o = 8'h71;  8'h57: code_o = 8'h79;
      8'h58: code_o = 8'h7B;
      8'h32: begin code_o = 8'h1F; e0_o = 1'b1; end
      8'h33: begin code_o = 8'h2F; e0_o = 1'b1; end
      8'h40: begin code_o = 8'h7C; e0_o = 1'b1; end
      8'h41: begin code_o = 8'h70; e0_o = 1'b1; end
      8'h42: begin code_o = 8'h6C; e0_o = 1'b1; end
      8'h43: begin code_o = 8'h7D; e0_o = 1'b1; end
      8'h44: begin code_o = 8'h7A; e0_o = 1'b1; end
      8'h45: begin code_o = 8'h71; e0_o = 1'b1; end
      8'h46: begin code_o = 8'h69; e0_o = 1'b1; end
      8'h47: begin code_o = 8'h75; e0_o = 1'b1; end
      8'h48: begin code_o = 8'h72; e0_o = 1'b1; end
      8'h49: begin code_o = 8'h6B; e0_o = 1'b1; end
      8'h4A: begin code_o = 8'h74; e0_o = 1'b1; end
      8'h59: begin code_o = 8'h4A; e0_o = 1'b1; end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/keycode_to_scancode.sv
// Serialises one keycode request into set-2 scancode bytes over a strobe/ready link.
// Optional macro SCANCODE_PAUSE_EN enables the PAUSE (keycode 5A) make sequence.
module keycode_to_scancode
  import scancode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_data,
  input  logic       key_broken,
  input  logic       key_data_stb,
  output logic       key_ready,
  output logic [7:0] tx_data,
  output logic       tx_stb,
  input  logic       tx_ready,
  output logic       key_invalid
);

  state_t     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       brk_q, brk_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_stb_q, tx_stb_d;
  logic       key_invalid_q, key_invalid_d;
`ifdef SCANCODE_PAUSE_EN
  logic [2:0] idx_q, idx_d;
`endif

  logic [7:0] lut_code_s;
  logic       lut_e0_s;
  logic       lut_valid_s;
  logic       accept_s;
  logic       hs_s;

  keycode_lut u_lut (
    .keycode_i (key_data),
    .code_o    (lut_code_s),
    .e0_o      (lut_e0_s),
    .valid_o   (lut_valid_s)
  );

  assign accept_s    = key_data_stb && (state_q == IDLE);
  assign hs_s        = tx_stb_q && tx_ready;
  assign key_ready   = (state_q == IDLE);
  assign tx_data     = tx_data_q;
  assign tx_stb      = tx_stb_q;
  assign key_invalid = key_invalid_q;

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    brk_d         = brk_q;
    tx_data_d     = tx_data_q;
    tx_stb_d      = tx_stb_q;
    key_invalid_d = 1'b0;
`ifdef SCANCODE_PAUSE_EN
    idx_d         = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          code_d = lut_code_s;
          brk_d  = key_broken;
`ifdef SCANCODE_PAUSE_EN
          if (key_data == KEY_PAUSE) begin
            if (!key_broken) begin
              state_d   = PAUSE_SEQ;
              idx_d     = 3'd0;
              tx_data_d = pause_byte(3'd0);
              tx_stb_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else
`endif
          if (!lut_valid_s) begin
            key_invalid_d = 1'b1;
          end else if (lut_e0_s) begin
            state_d   = PREFIX;
            tx_data_d = PREFIX_E0;
            tx_stb_d  = 1'b1;
          end else if (key_broken) begin
            state_d   = BREAK;
            tx_data_d = PREFIX_F0;
            tx_stb_d  = 1'b1;
          end else begin
            state_d   = CODE;
            tx_data_d = lut_code_s;
            tx_stb_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PREFIX: begin
        if (hs_s) begin
          state_d   = brk_q ? BREAK : CODE;
          tx_data_d = brk_q ? PREFIX_F0 : code_q;
        end else begin
          state_d = PREFIX;
        end
      end
      BREAK: begin
        if (hs_s) begin
          state_d   = CODE;
          tx_data_d = code_q;
        end else begin
          state_d = BREAK;
        end
      end
      CODE: begin
        if (hs_s) begin
          state_d   = IDLE;
          tx_data_d = 8'h00;
          tx_stb_d  = 1'b0;
        end else begin
          state_d = CODE;
        end
      end
`ifdef SCANCODE_PAUSE_EN
      PAUSE_SEQ: begin
        if (hs_s && (idx_q == 3'd7)) begin
          state_d   = IDLE;
          tx_data_d = 8'h00;
          tx_stb_d  = 1'b0;
        end else if (hs_s) begin
          idx_d     = idx_q + 3'd1;
          tx_data_d = pause_byte(idx_q + 3'd1);
        end else begin
          state_d = PAUSE_SEQ;
        end
      end
`endif
      default: begin
        state_d   = IDLE;
        tx_data_d = 8'h00;
        tx_stb_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any partial sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      code_q        <= 8'h00;
      brk_q         <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_stb_q      <= 1'b0;
      key_invalid_q <= 1'b0;
`ifdef SCANCODE_PAUSE_EN
      idx_q         <= 3'd0;
`endif
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      brk_q         <= brk_d;
      tx_data_q     <= tx_data_d;
      tx_stb_q      <= tx_stb_d;
      key_invalid_q <= key_invalid_d;
`ifdef SCANCODE_PAUSE_EN
      idx_q         <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_keycode_to_scancode.sv
// Randomised self-checking bench for keycode_to_scancode against a table-driven byte-list model.
// Honours SCANCODE_PAUSE_EN to select the expected PAUSE behaviour.
module tb_keycode_to_scancode;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_data;
  logic       key_broken;
  logic       key_data_stb;
  logic       key_ready;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_ready;
  logic       key_invalid;

  int errors = 0;
  int checks = 0;

  // kind: 0 unmapped, 1 plain, 2 E0-prefixed, 3 pause
  int         kind_tab [256];
  logic [7:0] code_tab [256];
  logic [7:0] exp_q [$];

  keycode_to_scancode dut (
    .clk          (clk),
    .rst          (rst),
    .key_data     (key_data),
    .key_broken   (key_broken),
    .key_data_stb (key_data_stb),
    .key_ready    (key_ready),
    .tx_data      (tx_data),
    .tx_stb       (tx_stb),
    .tx_ready     (tx_ready),
    .key_invalid  (key_invalid)
  );

  always #5 clk = ~clk;

  task automatic build_model();
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] misc [13]    = '{8'h76, 8'h66, 8'h0D, 8'h58, 8'h77, 8'h29, 8'h05, 8'h06, 8'h12,
                                 8'h14, 8'h11, 8'h5A, 8'h7E};
    logic [7:0] punct [12]   = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h0E, 8'h41,
                                 8'h49, 8'h4A, 8'h59};
    logic [7:0] keypad [13]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75,
                                 8'h7D, 8'h71, 8'h79, 8'h7B};
    logic [7:0] e0_keys [14] = '{8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                                 8'h47, 8'h48, 8'h49, 8'h4A, 8'h59};
    logic [7:0] e0_codes [14] = '{8'h1F, 8'h2F, 8'h7C, 8'h70, 8'h6C, 8'h7D, 8'h7A, 8'h71, 8'h69,
                                  8'h75, 8'h72, 8'h6B, 8'h74, 8'h4A};
    for (int i = 0; i < 256; i++) begin kind_tab[i] = 0; code_tab[i] = 8'h00; end
    for (int i = 0; i < 26; i++) begin kind_tab[8'h01 + i] = 1; code_tab[8'h01 + i] = letters[i]; end
    for (int i = 0; i < 10; i++) begin kind_tab[8'h1B + i] = 1; code_tab[8'h1B + i] = digits[i]; end
    for (int i = 0; i < 13; i++) begin kind_tab[8'h25 + i] = 1; code_tab[8'h25 + i] = misc[i]; end
    for (int i = 0; i < 12; i++) begin kind_tab[8'h34 + i] = 1; code_tab[8'h34 + i] = punct[i]; end
    for (int i = 0; i < 13; i++) begin kind_tab[8'h4C + i] = 1; code_tab[8'h4C + i] = keypad[i]; end
    for (int i = 0; i < 14; i++) begin kind_tab[e0_keys[i]] = 2; code_tab[e0_keys[i]] = e0_codes[i]; end
`ifdef SCANCODE_PAUSE_EN
    kind_tab[8'h5A] = 3;
`endif
  endtask

  task automatic build_expect(input logic [7:0] key, input logic brk);
    exp_q.delete();
    case (kind_tab[key])
      1: begin if (brk) exp_q.push_back(8'hF0); exp_q.push_back(code_tab[key]); end
      2: begin exp_q.push_back(8'hE0); if (brk) exp_q.push_back(8'hF0); exp_q.push_back(code_tab[key]); end
      3: if (!brk) exp_q = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      default: ;
    endcase
  endtask

  // Issue one request, then check every presented byte (including stall cycles) and the return to idle.
  task automatic run_request(input logic [7:0] key, input logic brk, input int stall0,
                             input bit rnd, input string name);
    int  i;
    int  cyc;
    logic exp_inv;
    build_expect(key, brk);
    exp_inv = (kind_tab[key] == 0);
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before: got %b expected 1", name, key_ready); end
    key_data = key; key_broken = brk; key_data_stb = 1'b1; tx_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    key_data_stb = 1'b0; key_data = 8'($urandom); key_broken = 1'($urandom);
    if (exp_q.size() == 0) begin
      checks++;
      if (key_invalid !== exp_inv) begin errors++; $display("FAIL %s invalid_pulse: got %b expected %b", name, key_invalid, exp_inv); end
      checks++;
      if (tx_stb !== 1'b0) begin errors++; $display("FAIL %s no_tx: got tx_stb=%b expected 0", name, tx_stb); end
      checks++;
      if (key_ready !== 1'b1) begin errors++; $display("FAIL %s stay_idle: got key_ready=%b expected 1", name, key_ready); end
      @(negedge clk);
      checks++;
      if (key_invalid !== 1'b0 || tx_stb !== 1'b0) begin
        errors++; $display("FAIL %s after_pulse: got inv=%b stb=%b expected 0 0", name, key_invalid, tx_stb);
      end
    end else begin
      checks++;
      if (key_invalid !== 1'b0) begin errors++; $display("FAIL %s spurious_invalid: got %b expected 0", name, key_invalid); end
      i = 0; cyc = 0;
      while (i < exp_q.size() && cyc < 200) begin
        checks++;
        if (tx_stb !== 1'b1 || tx_data !== exp_q[i] || key_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s byte%0d: got stb=%b data=%02h ready=%b expected stb=1 data=%02h ready=0",
                   name, i, tx_stb, tx_data, key_ready, exp_q[i]);
        end
        tx_ready = (i == 0 && cyc < stall0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        key_data_stb = 1'($urandom_range(0, 1)); key_data = 8'($urandom);
        if (tx_ready) i++;
        cyc++;
        @(negedge clk);
      end
      key_data_stb = 1'b0;
      checks++;
      if (i < exp_q.size()) begin errors++; $display("FAIL %s timeout: got %0d bytes expected %0d", name, i, exp_q.size()); end
      checks++;
      if (tx_stb !== 1'b0 || key_ready !== 1'b1 || key_invalid !== 1'b0) begin
        errors++; $display("FAIL %s end_idle: got stb=%b ready=%b inv=%b expected 0 1 0", name, tx_stb, key_ready, key_invalid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_data = 8'h00; key_broken = 1'b0; key_data_stb = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_stb !== 1'b0 || tx_data !== 8'h00 || key_invalid !== 1'b0 || key_ready !== 1'b1) begin
      errors++; $display("FAIL reset_values: got stb=%b data=%02h inv=%b ready=%b expected 0 00 0 1", tx_stb, tx_data, key_invalid, key_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_make_basic();
    run_request(8'h01, 1'b0, 0, 1'b0, "make_A");
    run_request(8'h2D, 1'b0, 0, 1'b0, "make_lshift");
  endtask

  task automatic test_break_e0();
    run_request(8'h47, 1'b1, 0, 1'b0, "break_up");
    run_request(8'h59, 1'b0, 0, 1'b0, "make_kp_slash");
  endtask

  task automatic test_stall();
    run_request(8'h2A, 1'b1, 5, 1'b0, "stall_space_break");
  endtask

  task automatic test_invalid();
    run_request(8'h00, 1'b0, 0, 1'b0, "invalid_00");
    run_request(8'h7F, 1'b1, 0, 1'b0, "invalid_7F");
    run_request(8'h4B, 1'b0, 0, 1'b0, "invalid_4B");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    key_data = 8'h45; key_broken = 1'b1; key_data_stb = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    key_data_stb = 1'b0;
    checks++;
    if (tx_stb !== 1'b1 || tx_data !== 8'hE0) begin errors++; $display("FAIL rst_mid_e0: got stb=%b data=%02h expected 1 E0", tx_stb, tx_data); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (tx_stb !== 1'b0 || tx_data !== 8'h00 || key_ready !== 1'b1 || key_invalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_abort: got stb=%b data=%02h ready=%b inv=%b expected 0 00 1 0", tx_stb, tx_data, key_ready, key_invalid);
    end
    @(negedge clk);
    checks++;
    if (tx_stb !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_hold: got stb=%b ready=%b expected 0 1", tx_stb, key_ready); end
    rst = 1'b0;
    run_request(8'h01, 1'b0, 0, 1'b0, "after_rst_make_A");
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (tx_stb !== 1'b0) begin errors++; $display("FAIL rst_no_resume: got stb=%b expected 0", tx_stb); end
    end
  endtask

  task automatic test_pause();
    run_request(8'h5A, 1'b0, 0, 1'b1, "pause_make");
    run_request(8'h5A, 1'b1, 0, 1'b0, "pause_break");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      run_request(8'($urandom_range(0, 255)), 1'($urandom), $urandom_range(0, 2), 1'b1, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] keys [6] = '{8'h1B, 8'h32, 8'h30, 8'h58, 8'h4A, 8'h3F};
    for (int n = 0; n < 6; n++) run_request(keys[n], n[0], 0, 1'b0, "back_to_back");
  endtask

  initial begin
    build_model();
    test_reset();
    test_make_basic();
    test_break_e0();
    test_stall();
    test_invalid();
    test_reset_mid();
    test_pause();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
